// File: rtl/vx_dispatch_multi.sv
// vx_dispatch_multi: routes one operand packet per cycle into per-unit FIFOs,
// tagging each with its last active thread, counting stalls and trapping bad unit codes.
module vx_dispatch_multi #(
  parameter int DATAW       = 64,
  parameter int NUM_THREADS = 4,
  parameter int NUM_UNITS   = 4,
  parameter int DEPTH       = 4,
  parameter int CTR_BITS    = 16,
  localparam int NTW = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1,
  localparam int EXW = $clog2(NUM_UNITS + 1),
  localparam int CW  = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXW-1:0]                  in_ex_type,
  input  logic [NUM_THREADS-1:0]          in_tmask,
  input  logic [DATAW-1:0]                in_data,
  output logic [NUM_UNITS-1:0]            out_valid,
  input  logic [NUM_UNITS-1:0]            out_ready,
  output logic [NUM_UNITS*(DATAW+NTW)-1:0] out_data,
  output logic [NUM_UNITS*CW-1:0]         out_count,
  output logic [NUM_UNITS*CTR_BITS-1:0]   perf_stalls,
  output logic                            bad_type,
  input  logic                            clr_stats
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DATAW + NTW;
  logic [NTW-1:0]       last_tid;
  logic [NUM_UNITS-1:0] sel, full;
  logic                 bad_sel, bad_q, bad_d;
  always_comb begin
    last_tid = '0;
    for (int i = 0; i < NUM_THREADS; i++) last_tid = in_tmask[i] ? NTW'(i) : last_tid;
  end
  // sel is one-hot for in-range codes, so this picks ~full of the addressed unit
  assign bad_sel  = in_ex_type >= EXW'(NUM_UNITS);
  assign in_ready = bad_sel | (|(sel & ~full));
  assign bad_d    = clr_stats ? 1'b0 : bad_q | (in_valid & bad_sel);
  assign bad_type = bad_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bad_q <= 1'b0;
    else bad_q <= bad_d;
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    logic [PW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CTR_BITS-1:0] stall_q, stall_d;
    logic                push, pop;
    assign sel[u]   = in_ex_type == EXW'(u);
    assign full[u]  = cnt_q == CW'(DEPTH);
    assign push     = in_valid & sel[u] & ~full[u];
    assign pop      = out_valid[u] & out_ready[u];
    assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
    assign stall_d  = clr_stats ? '0 : (in_valid & sel[u] & full[u] & ~&stall_q) ? stall_q + CTR_BITS'(1) : stall_q;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        cnt_q   <= '0;
        stall_q <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= {last_tid, in_data};
          wptr_q        <= wptr_q + AW'(1);
        end
        if (pop) rptr_q <= rptr_q + AW'(1);
        cnt_q   <= cnt_d;
        stall_q <= stall_d;
      end
    assign out_valid[u]                         = cnt_q != '0;
    assign out_data[u*PW +: PW]                 = mem_q[rptr_q];
    assign out_count[u*CW +: CW]                = cnt_q;
    assign perf_stalls[u*CTR_BITS +: CTR_BITS]  = stall_q;
  end
endmodule

// File: tb/tb_vx_dispatch_multi.sv
// tb_vx_dispatch_multi: directed and randomized checks of vx_dispatch_multi
// against a queue-based reference model.
module tb_vx_dispatch_multi;
  localparam int DATAW = 64, NT = 4, NU = 4, DEPTH = 4, CB = 4;
  localparam int NTW = 2, EXW = 3, CW = 3, PW = DATAW + NTW;
  localparam int SMAX = (1 << CB) - 1;
  logic clk = 0, reset_n = 0, in_valid = 0, clr_stats = 0;
  logic in_ready, bad_type;
  logic [EXW-1:0] in_ex_type = '0;
  logic [NT-1:0] in_tmask = '0;
  logic [DATAW-1:0] in_data = '0;
  logic [NU-1:0] out_valid, out_ready = '0;
  logic [NU*PW-1:0] out_data;
  logic [NU*CW-1:0] out_count;
  logic [NU*CB-1:0] perf_stalls;
  int errors = 0, checks = 0;
  logic [PW-1:0] mq [NU][$];
  int ms [NU];
  bit mbad;

  vx_dispatch_multi #(.DATAW(DATAW), .NUM_THREADS(NT), .NUM_UNITS(NU), .DEPTH(DEPTH), .CTR_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_ex_type(in_ex_type),
    .in_tmask(in_tmask), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .perf_stalls(perf_stalls), .bad_type(bad_type),
    .clr_stats(clr_stats));

  always #5 clk = ~clk;

  function automatic int tid_of(logic [NT-1:0] m);
    return m == 0 ? 0 : $clog2(int'(m) + 1) - 1;
  endfunction

  function automatic bit m_ready();
    if (int'(in_ex_type) >= NU) return 1'b1;
    return mq[in_ex_type].size() < DEPTH;
  endfunction

  function automatic void model_clear();
    for (int u = 0; u < NU; u++) begin
      mq[u].delete();
      ms[u] = 0;
    end
    mbad = 0;
  endfunction

  // One clock edge: decide accept/pop/stall from pre-edge state, then update the model.
  task automatic tick();
    bit rdy, stall, badin, clr;
    int ex;
    logic [PW-1:0] pkt;
    bit [NU-1:0] pop;
    rdy   = m_ready();
    ex    = int'(in_ex_type);
    pkt   = {NTW'(tid_of(in_tmask)), in_data};
    stall = in_valid && !rdy;
    badin = in_valid && ex >= NU;
    clr   = clr_stats;
    for (int u = 0; u < NU; u++) pop[u] = mq[u].size() > 0 && out_ready[u];
    @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) if (pop[u]) void'(mq[u].pop_front());
    if (in_valid && rdy && ex < NU) mq[ex].push_back(pkt);
    for (int u = 0; u < NU; u++)
      ms[u] = clr ? 0 : (stall && ex == u) ? (ms[u] + 1 > SMAX ? SMAX : ms[u] + 1) : ms[u];
    mbad = clr ? 1'b0 : (mbad | badin);
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_count got=%h exp=0", out_count); end
    checks++; if (perf_stalls !== '0) begin errors++; $display("FAIL reset_stalls got=%h exp=0", perf_stalls); end
    checks++; if (bad_type !== 1'b0) begin errors++; $display("FAIL reset_bad got=%b exp=0", bad_type); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    reset_n = 1;
  endtask

  task automatic test_unit2();
    in_valid = 1; in_ex_type = 2; in_tmask = 4'b0110; in_data = 64'hA5;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL u2_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL u2_valid got=%b exp=0100", out_valid); end
    checks++; if (out_data[2*PW +: PW] !== {2'd2, 64'hA5}) begin errors++; $display("FAIL u2_data got=%h exp=%h", out_data[2*PW +: PW], {2'd2, 64'hA5}); end
    checks++; if (out_count[2*CW +: CW] !== 3'd1) begin errors++; $display("FAIL u2_count got=%0d exp=1", out_count[2*CW +: CW]); end
    out_ready = 4'hF;
    tick();
    out_ready = 0;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL u2_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_fill_stall();
    out_ready = 0;
    in_ex_type = 1; in_tmask = 4'b0001;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_data = 64'(i + 1);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
    end
    in_data = 64'hDEAD;
    #1;
    checks++; if (out_count[1*CW +: CW] !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", out_count[1*CW +: CW]); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
    repeat (3) tick();
    in_valid = 0;
    #1;
    checks++; if (perf_stalls[1*CB +: CB] !== 4'd3) begin errors++; $display("FAIL fill_stalls got=%0d exp=3", perf_stalls[1*CB +: CB]); end
    out_ready = 4'b0010;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (out_valid[1] !== 1'b1 || out_data[1*PW +: PW] !== {2'd0, 64'(i + 1)}) begin
        errors++; $display("FAIL fill_order[%0d] got=%b/%h exp=1/%h", i, out_valid[1], out_data[1*PW +: PW], {2'd0, 64'(i + 1)});
      end
      tick();
    end
    out_ready = 0;
    #1;
    checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", out_valid[1]); end
  endtask

  task automatic test_bad_type();
    in_valid = 1; in_ex_type = 5; in_data = 64'h55;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bad_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    checks++; if (bad_type !== 1'b1) begin errors++; $display("FAIL bad_set got=%b exp=1", bad_type); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bad_valid got=%b exp=0000", out_valid); end
    clr_stats = 1;
    tick();
    clr_stats = 0;
    #1;
    checks++; if (bad_type !== 1'b0) begin errors++; $display("FAIL bad_clr got=%b exp=0", bad_type); end
    checks++; if (perf_stalls !== '0) begin errors++; $display("FAIL clr_stalls got=%h exp=0", perf_stalls); end
  endtask

  task automatic test_tid();
    out_ready = 0;
    in_valid = 1; in_ex_type = 0; in_tmask = 4'b0000; in_data = 64'd1;
    tick();
    in_tmask = 4'b1000; in_data = 64'd2;
    tick();
    in_valid = 0; out_ready = 4'b0001;
    #1;
    checks++; if (out_data[0 +: PW] !== {2'd0, 64'd1}) begin errors++; $display("FAIL tid0 got=%h exp=%h", out_data[0 +: PW], {2'd0, 64'd1}); end
    tick();
    #1;
    checks++; if (out_data[0 +: PW] !== {2'd3, 64'd2}) begin errors++; $display("FAIL tid3 got=%h exp=%h", out_data[0 +: PW], {2'd3, 64'd2}); end
    tick();
    out_ready = 0;
  endtask

  task automatic test_saturate();
    out_ready = 0;
    in_valid = 1; in_ex_type = 0; in_tmask = 4'b0011;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 64'(100 + i);
      tick();
    end
    repeat (20) tick();
    in_valid = 0;
    #1;
    checks++; if (perf_stalls[0 +: CB] !== 4'd15) begin errors++; $display("FAIL sat_stalls got=%0d exp=15", perf_stalls[0 +: CB]); end
    out_ready = 4'hF;
    repeat (DEPTH + 1) tick();
    out_ready = 0;
  endtask

  task automatic test_random(int n);
    for (int c = 0; c < n; c++) begin
      in_valid   = ($urandom % 4) != 0;
      in_ex_type = EXW'($urandom_range(0, 5));
      in_tmask   = NT'($urandom);
      in_data    = {$urandom, $urandom};
      out_ready  = NU'($urandom);
      clr_stats  = ($urandom % 40) == 0;
      #1;
      checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
      checks++; if (bad_type !== mbad) begin errors++; $display("FAIL rnd_bad c=%0d got=%b exp=%b", c, bad_type, mbad); end
      for (int u = 0; u < NU; u++) begin
        checks++; if (out_valid[u] !== (mq[u].size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] c=%0d got=%b exp=%b", u, c, out_valid[u], mq[u].size() != 0); end
        checks++; if (out_count[u*CW +: CW] !== CW'(mq[u].size())) begin errors++; $display("FAIL rnd_count[%0d] c=%0d got=%0d exp=%0d", u, c, out_count[u*CW +: CW], mq[u].size()); end
        checks++; if (perf_stalls[u*CB +: CB] !== CB'(ms[u])) begin errors++; $display("FAIL rnd_stalls[%0d] c=%0d got=%0d exp=%0d", u, c, perf_stalls[u*CB +: CB], ms[u]); end
        if (mq[u].size() != 0) begin
          checks++; if (out_data[u*PW +: PW] !== mq[u][0]) begin errors++; $display("FAIL rnd_data[%0d] c=%0d got=%h exp=%h", u, c, out_data[u*PW +: PW], mq[u][0]); end
        end
      end
      tick();
    end
    in_valid = 0; clr_stats = 0; out_ready = 4'hF;
    repeat (DEPTH + 1) tick();
    out_ready = 0;
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_ex_type = 3; in_tmask = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      in_data = 64'(200 + i);
      tick();
    end
    in_valid = 0;
    #1;
    checks++; if (out_count[3*CW +: CW] !== CW'(mq[3].size())) begin errors++; $display("FAIL ar_pre_count got=%0d exp=%0d", out_count[3*CW +: CW], mq[3].size()); end
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
    checks++; if (out_count[3*CW +: CW] !== 3'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", out_count[3*CW +: CW]); end
    model_clear();
    @(posedge clk);
    #1 reset_n = 1;
    tick();
    #1;
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL ar_post_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_unit2();
    test_fill_stall();
    test_bad_type();
    test_tid();
    test_saturate();
    test_random(600);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vx_dispatch_multi.md
Name: vx_dispatch_multi

Overview:
Parametrised successor of the core dispatch stage: routes one operand packet per cycle to one of NUM_UNITS execution-unit channels, each with its own FIFO of configurable depth. Appends last-active-thread index, counts per-unit stall cycles with saturation, and traps out-of-range unit codes. Sits between the operand collector and the execution units.

Parameters:
DATAW, 64, payload width (opaque)
NUM_THREADS, 4, thread-mask width
NUM_UNITS, 4, execution-unit channels (2..8)
DEPTH, 4, per-channel FIFO entries, power of 2, >=2
CTR_BITS, 16, stall counter width
NTW, max(1,clog2(NUM_THREADS)), tid width; EXW = clog2(NUM_UNITS+1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  packet valid
in_ready  out  1  packet accepted when valid&ready
in_ex_type  in  EXW  target unit index
in_tmask  in  NUM_THREADS  active thread mask
in_data  in  DATAW  payload
out_valid  out  NUM_UNITS  per-unit valid
out_ready  in  NUM_UNITS  per-unit ready
out_data  out  NUM_UNITS*(DATAW+NTW)  per unit {last_tid, payload}, unit u at slice u
out_count  out  NUM_UNITS*(clog2(DEPTH)+1)  per-unit occupancy
perf_stalls  out  NUM_UNITS*CTR_BITS  per-unit saturating stall counts
bad_type  out  1  sticky: out-of-range ex_type consumed
clr_stats  in  1  synchronous clear of perf_stalls and bad_type

Behaviour:
- Reset (reset_n=0, async): all FIFO pointers/counts 0, out_valid=0, out_count=0, perf_stalls=0, bad_type=0; out_data don't-care but must be 0 from registered storage to keep X off the bus.
- last_tid = index of highest set bit of in_tmask; in_tmask=0 -> 0. Computed combinationally, stored with payload.
- Routing: ex_type<NUM_UNITS selects FIFO u; in_ready = ~full[u] (combinational from FIFO state only, never from in_valid).
- ex_type>=NUM_UNITS: in_ready=1, packet dropped, bad_type set next cycle; stays set until clr_stats or reset.
- FIFO u: registered storage, write at tail on accept, out_data[u] = head entry; out_valid[u]=count[u]!=0. Latency accept->out_valid: 1 cycle.
- Pop on out_valid[u]&out_ready[u]. Simultaneous push+pop to same FIFO: count unchanged, legal even when full? No: full -> in_ready=0 regardless of pop (no bypass of full). When empty, push+pop same cycle impossible (out_valid=0).
- Pointers wrap modulo DEPTH; count range 0..DEPTH.
- Stall: in_valid & ~in_ready & ex_type==u -> perf_stalls[u] += 1 on next edge, saturating at all-ones. clr_stats has priority over increment in same cycle.
- out_valid/out_data must not change while out_valid&~out_ready (AXI-style hold).
- Reset asserted mid-operation: all queued packets discarded immediately; no output valid until new accept after reset_n rises.

Test Plan:
- Reset then in_valid with ex_type=2, tmask=4'b0110, data=0xA5 -> next cycle out_valid=4'b0100, out_data[2]={tid=2,0xA5}, out_count[2]=1.
- Unit 1 out_ready=0, push 4 packets to unit 1 (DEPTH=4) -> out_count[1]=4, in_ready=0 for 5th; holding 3 cycles -> perf_stalls[1]=3; then out_ready=1 -> packets emerge in order 1 per cycle.
- ex_type=5 (NUM_UNITS=4) -> in_ready=1, no out_valid, bad_type=1 next cycle; clr_stats pulse -> bad_type=0.
- tmask=0 and tmask=4'b1000 -> last_tid 0 and 3 respectively.
- CTR_BITS=4, stall unit 0 for 20 cycles -> perf_stalls[0]=15 (saturates).
- 2 entries queued in unit 3, assert reset_n=0 mid-cycle -> out_valid=0 and out_count[3]=0 immediately without clock edge.
